// File: rtl/mips_pkg.sv
// Shared MIPS writeback types: register index, data word and requester identifiers.
package mips_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

endpackage

// File: rtl/mips_wb_scoreboard.sv
// Pending-load scoreboard: tracks registers awaiting an LSU writeback and flags
// decode-stage read-after-load hazards. Only built with MIPS_WB_SCOREBOARD_EN.
module mips_wb_scoreboard
  import mips_pkg::*;
(
  input  logic      CLK,
  input  logic      rst,
  input  logic      issue_valid_i,
  input  reg_addr_t issue_addr_i,
  output logic      issue_ready_o,
  input  reg_addr_t rs_addr_i,
  input  reg_addr_t rt_addr_i,
  output logic      hazard_o,
  input  logic      lsu_wr_en_i,
  input  reg_addr_t lsu_wr_addr_i
);

  logic [31:0] pend_q, pend_d;

  assign issue_ready_o = !pend_q[issue_addr_i] || (issue_addr_i == REG_ZERO);
  assign hazard_o      = pend_q[rs_addr_i] | pend_q[rt_addr_i];

  // The set is applied after the clear so a re-issue in the writeback cycle stays pending.
  always_comb begin
    pend_d = pend_q;
    if (lsu_wr_en_i) pend_d[lsu_wr_addr_i] = 1'b0;
    if (issue_valid_i && issue_ready_o && (issue_addr_i != REG_ZERO))
      pend_d[issue_addr_i] = 1'b1;
    pend_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

endmodule

// File: rtl/mips_wb_arbiter.sv
// Writeback arbiter: ALU has fixed priority, LSU is forced through after MAX_WAIT losses.
// Optional pending-load scoreboard enabled by defining MIPS_WB_SCOREBOARD_EN.
module mips_wb_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 3,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              alu_valid,
  input  reg_addr_t         alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  reg_addr_t         lsu_addr,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
`ifdef MIPS_WB_SCOREBOARD_EN
  input  logic              issue_valid,
  input  reg_addr_t         issue_addr,
  output logic              issue_ready,
  input  reg_addr_t         rs_addr,
  input  reg_addr_t         rt_addr,
  output logic              hazard,
`endif
  output logic              RegWrite,
  output reg_addr_t         WriteAddress,
  output logic [DATA_W-1:0] DataIn
);

  localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              regwrite_q;
  reg_addr_t         waddr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              force_lsu;
  logic              grant_vld;
  req_e              grant_src;
  reg_addr_t         grant_addr;
  logic [DATA_W-1:0] grant_data;

  assign force_lsu = lsu_valid && (wait_cnt_q == CNT_MAX);

  always_comb begin
    grant_vld = 1'b0;
    grant_src = REQ_ALU;
    if (!rst) begin
      if (force_lsu) begin
        grant_vld = 1'b1;
        grant_src = REQ_LSU;
      end else if (alu_valid) begin
        grant_vld = 1'b1;
        grant_src = REQ_ALU;
      end else if (lsu_valid) begin
        grant_vld = 1'b1;
        grant_src = REQ_LSU;
      end
    end
  end

  assign alu_ready  = grant_vld && (grant_src == REQ_ALU);
  assign lsu_ready  = grant_vld && (grant_src == REQ_LSU);
  assign grant_addr = (grant_src == REQ_LSU) ? lsu_addr : alu_addr;
  assign grant_data = (grant_src == REQ_LSU) ? lsu_data : alu_data;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!lsu_valid || lsu_ready)  wait_cnt_d = '0;
    else if (wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
  end

`ifdef MIPS_WB_SCOREBOARD_EN
  logic wb_lsu_q;
`endif

  always_ff @(posedge CLK) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      waddr_q    <= REG_ZERO;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
`ifdef MIPS_WB_SCOREBOARD_EN
      wb_lsu_q   <= 1'b0;
`endif
    end else begin
      wait_cnt_q <= wait_cnt_d;
      regwrite_q <= grant_vld && (grant_addr != REG_ZERO);
      if (grant_vld) begin
        waddr_q <= grant_addr;
        wdata_q <= grant_data;
      end
`ifdef MIPS_WB_SCOREBOARD_EN
      wb_lsu_q   <= grant_vld && (grant_src == REQ_LSU);
`endif
    end
  end

  assign RegWrite     = regwrite_q;
  assign WriteAddress = waddr_q;
  assign DataIn       = wdata_q;

`ifdef MIPS_WB_SCOREBOARD_EN
  mips_wb_scoreboard u_scoreboard (
    .CLK           (CLK),
    .rst           (rst),
    .issue_valid_i (issue_valid),
    .issue_addr_i  (issue_addr),
    .issue_ready_o (issue_ready),
    .rs_addr_i     (rs_addr),
    .rt_addr_i     (rt_addr),
    .hazard_o      (hazard),
    .lsu_wr_en_i   (regwrite_q && wb_lsu_q),
    .lsu_wr_addr_i (waddr_q)
  );
`endif

endmodule
